// File: rtl/conv33_pkg.sv
// Shared types and tap decode for the 3x3 convolution sequencer.
// CONV33_PAD_EN selects zero padding of 1 (same-size output).
package conv33_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, CALC, WAIT, WRITE, DONE
  } state_t;

  localparam int TAPS  = 9;
  localparam int KSIZE = 3;

  // tap k -> (r,c), 2 bits per tap, tap 0 in the LSBs
  localparam logic [2*TAPS-1:0] TAP_ROW = {
    2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0
  };
  localparam logic [2*TAPS-1:0] TAP_COL = {
    2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0
  };

`ifdef CONV33_PAD_EN
  localparam int MIN_DIM = 1;
`else
  localparam int MIN_DIM = KSIZE;
`endif

  function automatic logic [1:0] tap_r(input logic [3:0] k);
    return (int'(k) < TAPS) ? TAP_ROW[2*int'(k) +: 2] : 2'd0;
  endfunction

  function automatic logic [1:0] tap_c(input logic [3:0] k);
    return (int'(k) < TAPS) ? TAP_COL[2*int'(k) +: 2] : 2'd0;
  endfunction

endpackage

// File: rtl/conv33_ctrl_if.sv
// Job, feature-RAM, datapath and output-RAM signals of conv33_ctrl.
// master = the sequencer, slave = its environment.
interface conv33_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
);
  logic                    start;
  logic [DIM_WIDTH-1:0]    img_w;
  logic [DIM_WIDTH-1:0]    img_h;
  logic [ADDR_WIDTH-1:0]   fm_base;
  logic [ADDR_WIDTH-1:0]   out_base;
  logic                    busy;
  logic                    done;
  logic                    fm_rd_en;
  logic [ADDR_WIDTH-1:0]   fm_addr;
  logic [DATA_WIDTH-1:0]   fm_rdata;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    conv33_en;
  logic                    calc_valid;
  logic                    out_wr_en;
  logic [ADDR_WIDTH-1:0]   out_addr;

  modport master (
    input  start, img_w, img_h, fm_base, out_base,
    input  fm_rdata, calc_valid,
    output busy, done, fm_rd_en, fm_addr,
    output win_data, conv33_en, out_wr_en, out_addr
  );

  modport slave (
    output start, img_w, img_h, fm_base, out_base,
    output fm_rdata, calc_valid,
    input  busy, done, fm_rd_en, fm_addr,
    input  win_data, conv33_en, out_wr_en, out_addr
  );
endinterface

// File: rtl/conv33_addr_gen.sv
// Combinational tap address generator for one window position.
// Under CONV33_PAD_EN it also flags taps that fall outside the image.
module conv33_addr_gen
  import conv33_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic [3:0]            i_tap,
  input  logic [DIM_WIDTH-1:0]  i_row,
  input  logic [DIM_WIDTH-1:0]  i_col,
  input  logic [DIM_WIDTH-1:0]  i_img_w,
  input  logic [DIM_WIDTH-1:0]  i_img_h,
  input  logic [ADDR_WIDTH-1:0] i_base,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_pad
);
  localparam int TW = DIM_WIDTH + 2;

  logic [TW-1:0] w_ty;
  logic [TW-1:0] w_tx;
  logic [TW-1:0] w_y;
  logic [TW-1:0] w_x;

  assign w_ty = TW'(i_row) + TW'(tap_r(i_tap));
  assign w_tx = TW'(i_col) + TW'(tap_c(i_tap));

`ifdef CONV33_PAD_EN
  // w_ty/w_tx are coordinates plus one, so 0 means row/col -1
  assign w_y   = w_ty - 1'b1;
  assign w_x   = w_tx - 1'b1;
  assign o_pad = (w_ty == '0) || (w_ty > TW'(i_img_h)) ||
                 (w_tx == '0) || (w_tx > TW'(i_img_w));
`else
  logic w_unused_h;
  assign w_unused_h = ^i_img_h;
  assign w_y   = w_ty;
  assign w_x   = w_tx;
  assign o_pad = 1'b0;
`endif

  assign o_addr = i_base
                + ADDR_WIDTH'(w_y) * ADDR_WIDTH'(i_img_w)
                + ADDR_WIDTH'(w_x);
endmodule

// File: rtl/conv33_ctrl.sv
// 3x3 convolution sequencer: window fetch, datapath kick, output write.
// Define CONV33_PAD_EN for zero padding of 1 (output = input size).
module conv33_ctrl
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input logic          clk,
  input logic          rst_n,
  conv33_ctrl_if.master bus
);
  state_t                     r_state;
  logic [3:0]                 r_tap;
  logic [DIM_WIDTH-1:0]       r_row;
  logic [DIM_WIDTH-1:0]       r_col;
  logic [DIM_WIDTH-1:0]       r_img_w;
  logic [DIM_WIDTH-1:0]       r_img_h;
  logic [ADDR_WIDTH-1:0]      r_fm_base;
  logic [ADDR_WIDTH-1:0]      r_out_base;
  logic [ADDR_WIDTH-1:0]      r_out_idx;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_rd_en;
  logic                       r_pad;
  logic [ADDR_WIDTH-1:0]      r_fm_addr;
  logic [TAPS*DATA_WIDTH-1:0] r_win;
  logic                       r_conv_en;
  logic                       r_wr_en;
  logic [ADDR_WIDTH-1:0]      r_out_addr;
  logic                       r_cap_vld;
  logic                       r_cap_pad;
  logic [3:0]                 r_cap_k;

  logic [DIM_WIDTH-1:0]  w_last_col;
  logic [DIM_WIDTH-1:0]  w_last_row;
  logic                  w_col_wrap;
  logic                  w_last_pos;
  logic [DIM_WIDTH-1:0]  w_nxt_col;
  logic [DIM_WIDTH-1:0]  w_nxt_row;
  logic                  w_small;
  logic [3:0]            w_ag_tap;
  logic [DIM_WIDTH-1:0]  w_ag_row;
  logic [DIM_WIDTH-1:0]  w_ag_col;
  logic [DIM_WIDTH-1:0]  w_ag_w;
  logic [DIM_WIDTH-1:0]  w_ag_h;
  logic [ADDR_WIDTH-1:0] w_ag_base;
  logic [ADDR_WIDTH-1:0] w_ag_addr;
  logic                  w_ag_pad;

  assign w_last_col = r_img_w - DIM_WIDTH'(MIN_DIM);
  assign w_last_row = r_img_h - DIM_WIDTH'(MIN_DIM);
  assign w_col_wrap = (r_col == w_last_col);
  assign w_last_pos = w_col_wrap && (r_row == w_last_row);
  assign w_nxt_col  = w_col_wrap ? '0 : r_col + 1'b1;
  assign w_nxt_row  = w_col_wrap ? r_row + 1'b1 : r_row;
  assign w_small    = (bus.img_w < DIM_WIDTH'(MIN_DIM)) ||
                      (bus.img_h < DIM_WIDTH'(MIN_DIM));

  // address the tap that will be on the bus next cycle
  always_comb begin
    w_ag_tap  = r_tap + 4'd1;
    w_ag_row  = r_row;
    w_ag_col  = r_col;
    w_ag_w    = r_img_w;
    w_ag_h    = r_img_h;
    w_ag_base = r_fm_base;
    unique case (r_state)
      IDLE: begin
        w_ag_tap  = '0;
        w_ag_row  = '0;
        w_ag_col  = '0;
        w_ag_w    = bus.img_w;
        w_ag_h    = bus.img_h;
        w_ag_base = bus.fm_base;
      end
      WRITE: begin
        w_ag_tap = '0;
        w_ag_row = w_nxt_row;
        w_ag_col = w_nxt_col;
      end
      default: ;
    endcase
  end

  conv33_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .i_tap   (w_ag_tap),
    .i_row   (w_ag_row),
    .i_col   (w_ag_col),
    .i_img_w (w_ag_w),
    .i_img_h (w_ag_h),
    .i_base  (w_ag_base),
    .o_addr  (w_ag_addr),
    .o_pad   (w_ag_pad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tap      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_img_w    <= '0;
      r_img_h    <= '0;
      r_fm_base  <= '0;
      r_out_base <= '0;
      r_out_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_pad      <= 1'b0;
      r_fm_addr  <= '0;
      r_win      <= '0;
      r_conv_en  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_out_addr <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_pad  <= 1'b0;
      r_cap_k    <= '0;
    end else begin
      // tap issued this cycle lands in the window one cycle later
      r_cap_vld <= (r_state == FETCH);
      r_cap_k   <= r_tap;
      r_cap_pad <= r_pad;
      if (r_cap_vld)
        r_win[int'(r_cap_k)*DATA_WIDTH +: DATA_WIDTH] <=
          r_cap_pad ? '0 : bus.fm_rdata;

      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_img_w    <= bus.img_w;
            r_img_h    <= bus.img_h;
            r_fm_base  <= bus.fm_base;
            r_out_base <= bus.out_base;
            r_row      <= '0;
            r_col      <= '0;
            r_out_idx  <= '0;
            r_tap      <= '0;
            if (w_small) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= FETCH;
              r_busy    <= 1'b1;
              r_rd_en   <= !w_ag_pad;
              r_pad     <= w_ag_pad;
              r_fm_addr <= w_ag_addr;
            end
          end
        end
        FETCH: begin
          if (r_tap == 4'(TAPS-1)) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
            r_pad   <= 1'b0;
          end else begin
            r_tap     <= r_tap + 4'd1;
            r_rd_en   <= !w_ag_pad;
            r_pad     <= w_ag_pad;
            r_fm_addr <= w_ag_addr;
          end
        end
        DRAIN: begin
          r_state   <= CALC;
          r_conv_en <= 1'b1;
        end
        CALC: begin
          r_state   <= WAIT;
          r_conv_en <= 1'b0;
        end
        WAIT: begin
          if (bus.calc_valid) begin
            r_state    <= WRITE;
            r_wr_en    <= 1'b1;
            r_out_addr <= r_out_base + r_out_idx;
          end
        end
        WRITE: begin
          r_wr_en   <= 1'b0;
          r_out_idx <= r_out_idx + 1'b1;
          r_row     <= w_nxt_row;
          r_col     <= w_nxt_col;
          r_tap     <= '0;
          if (w_last_pos) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= FETCH;
            r_rd_en   <= !w_ag_pad;
            r_pad     <= w_ag_pad;
            r_fm_addr <= w_ag_addr;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fm_rd_en  = r_rd_en;
  assign bus.fm_addr   = r_fm_addr;
  assign bus.win_data  = r_win;
  assign bus.conv33_en = r_conv_en;
  assign bus.out_wr_en = r_wr_en;
  assign bus.out_addr  = r_out_addr;
endmodule

// File: tb/tb_conv33_ctrl.sv
// Self-checking bench for conv33_ctrl: job table plus abort/pad sequences.
// Feature RAM returns (addr[7:0] + ofs); datapath answers after cur_lat.
module tb_conv33_ctrl;
`ifdef CONV33_PAD_EN
  localparam int PADN = 1;
`else
  localparam int PADN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv33_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DIM_WIDTH(8)) bus ();

  conv33_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .DIM_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [71:0] win;
  } sb_t;

  typedef struct {
    int          w;
    int          h;
    logic [15:0] fb;
    logic [15:0] ob;
    int          lat;
    int          dup_w;
    int          exp_n;
    int          exp_rf;
    logic [71:0] exp_win0;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] ofs = 8'd0;
  int cur_lat = 1;
  int vcnt = 0;
  sb_t sbq[$];
  sb_t mon_e;

  int busy_cnt, rd_cnt, rd_first, en_cnt, done_cnt, wr_cnt;
  int done_cyc, last_wr, st_cyc;
  logic [71:0] win0;

  task automatic check(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.fm_rd_en) bus.fm_rdata <= bus.fm_addr[7:0] + ofs;

  always @(posedge clk)
    if (!rst_n) vcnt <= 0;
    else if (bus.conv33_en) vcnt <= cur_lat;
    else if (vcnt != 0) vcnt <= vcnt - 1;

  assign bus.calc_valid = (vcnt == 1);

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.fm_rd_en) begin
      rd_cnt++;
      if (en_cnt == 0) rd_first++;
    end
    if (bus.conv33_en) en_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.out_wr_en) begin
      wr_cnt++;
      if (wr_cnt == 1) win0 = bus.win_data;
      else check("wr_gap", 72'(cyc - last_wr), 72'(12 + cur_lat));
      last_wr = cyc;
      if (sbq.size() == 0) begin
        check("sb_extra_write", 72'(bus.out_addr), 72'hDEAD_BEEF);
      end else begin
        mon_e = sbq.pop_front();
        check("wr_addr", 72'(bus.out_addr), 72'(mon_e.addr));
        check("wr_win", bus.win_data, mon_e.win);
      end
    end
  end

  function automatic logic [71:0] model_win(input int w, input int h,
      input logic [15:0] fb, input int row, input int col,
      output int nrd);
    logic [71:0] win;
    logic [15:0] a;
    int y, x;
    win = '0;
    nrd = 0;
    for (int k = 0; k < 9; k++) begin
      y = row - PADN + k / 3;
      x = col - PADN + k % 3;
      if (y >= 0 && y < h && x >= 0 && x < w) begin
        a = fb + 16'(y * w + x);
        win[k*8 +: 8] = a[7:0] + ofs;
        nrd++;
      end
    end
    return win;
  endfunction

  task automatic apply(input vec_t v, input int id);
    int ow, oh, nrd, nrd_tot;
    sb_t s;
    string t;
    t = $sformatf("v%0d", id);
    sbq.delete();
    busy_cnt = 0; rd_cnt = 0; rd_first = 0; en_cnt = 0;
    done_cnt = 0; wr_cnt = 0; done_cyc = 0; last_wr = 0;
    win0 = '0;
    nrd_tot = 0;
    cur_lat = v.lat;
    ow = v.w - 2 + 2 * PADN;
    oh = v.h - 2 + 2 * PADN;
    if (v.w >= 3 - 2 * PADN && v.h >= 3 - 2 * PADN)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          s.win  = model_win(v.w, v.h, v.fb, r, c, nrd);
          s.addr = v.ob + 16'(r * ow + c);
          nrd_tot += nrd;
          sbq.push_back(s);
        end
    @(posedge clk); #1;
    bus.img_w = 8'(v.w);
    bus.img_h = 8'(v.h);
    bus.fm_base = v.fb;
    bus.out_base = v.ob;
    bus.start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (v.dup_w > 0) begin
      repeat (2) @(posedge clk);
      #1;
      bus.img_w = 8'(v.dup_w);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    check({t, "_done_seen"}, 72'(done_cnt != 0), 72'd1);
    repeat (3) @(negedge clk);
    check({t, "_done_once"}, 72'(done_cnt), 72'd1);
    check({t, "_done_lat"}, 72'(done_cyc - st_cyc),
          72'(1 + v.exp_n * (12 + v.lat)));
    check({t, "_busy_cyc"}, 72'(busy_cnt), 72'(v.exp_n * (12 + v.lat)));
    check({t, "_writes"}, 72'(wr_cnt), 72'(v.exp_n));
    check({t, "_conv_en"}, 72'(en_cnt), 72'(v.exp_n));
    check({t, "_reads"}, 72'(rd_cnt), 72'(nrd_tot));
    check({t, "_reads_first"}, 72'(rd_first), 72'(v.exp_rf));
    if (v.exp_n > 0) check({t, "_win0"}, win0, v.exp_win0);
    check({t, "_sb_left"}, 72'(sbq.size()), 72'd0);
  endtask

  vec_t vec[8];
  vec_t hv;

  initial begin
    bus.start = 1'b0;
    bus.img_w = '0;
    bus.img_h = '0;
    bus.fm_base = '0;
    bus.out_base = '0;

    vec[0] = '{4, 4, 16'h0000, 16'h0100, 1, 0, PADN ? 16 : 4, PADN ? 4 : 9,
               PADN ? 72'h050400010000000000 : 72'h0A0908060504020100};
    vec[1] = '{4, 4, 16'h0000, 16'h0100, 5, 0, PADN ? 16 : 4, PADN ? 4 : 9,
               PADN ? 72'h050400010000000000 : 72'h0A0908060504020100};
    vec[2] = '{4, 4, 16'h0000, 16'h0100, 1, 6, PADN ? 16 : 4, PADN ? 4 : 9,
               PADN ? 72'h050400010000000000 : 72'h0A0908060504020100};
    vec[3] = '{2, 5, 16'h0000, 16'h0100, 1, 0, PADN ? 10 : 0, PADN ? 4 : 0,
               PADN ? 72'h030200010000000000 : 72'h0};
    vec[4] = '{5, 3, 16'h0040, 16'h0300, 2, 0, PADN ? 15 : 3, PADN ? 4 : 9,
               PADN ? 72'h464500414000000000 : 72'h4C4B4A474645424140};
    vec[5] = '{3, 3, 16'hFFFC, 16'h0010, 1, 0, PADN ? 9 : 1, PADN ? 4 : 9,
               PADN ? 72'h00FF00FDFC00000000 : 72'h0403020100FFFEFDFC};
    vec[6] = '{6, 4, 16'h0020, 16'hFFFE, 1, 0, PADN ? 24 : 8, PADN ? 4 : 9,
               PADN ? 72'h272600212000000000 : 72'h2E2D2C282726222120};
    vec[7] = '{3, 2, 16'h0000, 16'h0100, 1, 0, PADN ? 6 : 0, PADN ? 4 : 0,
               PADN ? 72'h040300010000000000 : 72'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 72'({bus.busy, bus.done, bus.fm_rd_en,
                          bus.conv33_en, bus.out_wr_en}), 72'd0);
    check("rst_fm_addr", 72'(bus.fm_addr), 72'd0);
    check("rst_out_addr", 72'(bus.out_addr), 72'd0);
    check("rst_win", bus.win_data, 72'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply(vec[i], i);

    // abort during the 5th FETCH cycle, then restart from the top
    cur_lat = 1;
    @(posedge clk); #1;
    bus.img_w = 8'd4;
    bus.img_h = 8'd4;
    bus.fm_base = 16'h0040;
    bus.out_base = 16'h0100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_fetch5_addr", 72'(bus.fm_addr),
          PADN ? 72'h40 : 72'h45);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ctl", 72'({bus.busy, bus.done, bus.fm_rd_en,
                            bus.conv33_en, bus.out_wr_en}), 72'd0);
    check("abort_fm_addr", 72'(bus.fm_addr), 72'd0);
    check("abort_win", bus.win_data, 72'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hv = '{4, 4, 16'h0040, 16'h0200, 1, 0, PADN ? 16 : 4, PADN ? 4 : 9,
           PADN ? 72'h454400414000000000 : 72'h4A4948464544424140};
    apply(hv, 8);

`ifdef CONV33_PAD_EN
    ofs = 8'd1;
    hv = '{3, 3, 16'h0000, 16'h0000, 1, 0, 9, 4, 72'h050400020100000000};
    apply(hv, 9);
    ofs = 8'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
